// File: rtl/unaligned_write_packer_pkg.sv
// Shared definitions for the unaligned window writer and its readers.
// Address-split helpers let every block derive identical field widths from WIDTH_BYTES.
package unaligned_write_packer_pkg;

    localparam int DEF_WIDTH_BYTES     = 8;
    localparam int DEF_SIZE_BYTES_LOG2 = 15;

    localparam int ADDR_UNALIGNED_PART = $clog2(DEF_WIDTH_BYTES);
    localparam int WORD_ADDR_BITS      = DEF_SIZE_BYTES_LOG2 - ADDR_UNALIGNED_PART;
    localparam int LEN_BITS            = ADDR_UNALIGNED_PART + 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } wp_state_e;

    function automatic int addr_unaligned_part(input int width_bytes);
        return $clog2(width_bytes);
    endfunction

    function automatic int word_addr_bits(input int width_bytes, input int size_log2);
        return size_log2 - $clog2(width_bytes);
    endfunction

    function automatic int len_bits(input int width_bytes);
        return $clog2(width_bytes) + 1;
    endfunction

endpackage

// File: rtl/unaligned_write_packer_byte_merge.sv
// Appends a beat at byte offset `fill` of the residual; bytes past fill+len come out zero,
// so both halves of the merged result are already zero-padded.
module byte_merge
    import unaligned_write_packer_pkg::*;
#(
    parameter int WIDTH_BYTES = DEF_WIDTH_BYTES,
    localparam int UA = addr_unaligned_part(WIDTH_BYTES),
    localparam int LB = len_bits(WIDTH_BYTES)
) (
    input  logic [WIDTH_BYTES-1:0][7:0]   resid,
    input  logic [UA-1:0]                 fill,
    input  logic [WIDTH_BYTES-1:0][7:0]   data,
    input  logic [LB-1:0]                 len,
    output logic [2*WIDTH_BYTES-1:0][7:0] merged,
    output logic [LB-1:0]                 total
);

    localparam logic [LB-1:0] LEN_MAX = LB'(WIDTH_BYTES);

    logic [LB-1:0]                len_eff;
    logic [WIDTH_BYTES-1:0][7:0]  resid_m;
    logic [WIDTH_BYTES-1:0][7:0]  data_m;

    always_comb begin
        len_eff = (len > LEN_MAX) ? LEN_MAX : len;
        total   = {1'b0, fill} + len_eff;
        for (int i = 0; i < WIDTH_BYTES; i++) begin
            resid_m[i] = (UA'(i) < fill)    ? resid[i] : 8'h00;
            data_m[i]  = (LB'(i) < len_eff) ? data[i]  : 8'h00;
        end
        merged = {{(8*WIDTH_BYTES){1'b0}}, resid_m}
               | ({{(8*WIDTH_BYTES){1'b0}}, data_m} << {fill, 3'b000});
    end

endmodule

// File: rtl/unaligned_write_packer.sv
// Packs variable-length byte beats into aligned word writes for the history window,
// with a one-cycle flush that publishes a partial word and a byte-exact committed pointer.
module unaligned_write_packer
    import unaligned_write_packer_pkg::*;
#(
    parameter int WIDTH_BYTES     = DEF_WIDTH_BYTES,
    parameter int SIZE_BYTES_LOG2 = DEF_SIZE_BYTES_LOG2,
    localparam int UA = addr_unaligned_part(WIDTH_BYTES),
    localparam int WA = word_addr_bits(WIDTH_BYTES, SIZE_BYTES_LOG2),
    localparam int LB = len_bits(WIDTH_BYTES)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_BYTES*8-1:0]   in_data,
    input  logic [LB-1:0]              in_len,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic                       write_enable,
    output logic [SIZE_BYTES_LOG2-1:0] write_address,
    output logic [WIDTH_BYTES*8-1:0]   write_data,
    output logic [SIZE_BYTES_LOG2-1:0] committed_ptr
);

    wp_state_e                   state_q, state_d;
    logic [UA-1:0]               fill_q, fill_d;
    logic [WA-1:0]               waddr_q, waddr_d;
    logic [WIDTH_BYTES-1:0][7:0] resid_q, resid_d;
    logic                        in_ready_q, in_ready_d;
    logic                        flush_done_q, flush_done_d;
    logic                        we_q, we_d;
    logic [SIZE_BYTES_LOG2-1:0]  wr_addr_q, wr_addr_d;
    logic [WIDTH_BYTES*8-1:0]    wr_data_q, wr_data_d;
    logic [SIZE_BYTES_LOG2-1:0]  cptr_q, cptr_d;

    logic [2*WIDTH_BYTES-1:0][7:0] merged;
    logic [LB-1:0]                 total;
    logic [WA-1:0]                 waddr_inc;
    logic                          accept;

    byte_merge #(.WIDTH_BYTES(WIDTH_BYTES)) u_merge (
        .resid  (resid_q),
        .fill   (fill_q),
        .data   (in_data),
        .len    (in_len),
        .merged (merged),
        .total  (total)
    );

    assign waddr_inc = waddr_q + 1'b1;
    assign accept    = in_valid & in_ready_q & (state_q == RUN);

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        waddr_d      = waddr_q;
        resid_d      = resid_q;
        flush_done_d = 1'b0;
        we_d         = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cptr_d       = cptr_q;
        unique case (state_q)
            RUN: begin
                if (accept) begin
                    fill_d = total[UA-1:0];
                    // total's top bit set means a whole word is ready; the low bits are the surplus
                    if (total[UA]) begin
                        we_d      = 1'b1;
                        wr_addr_d = {waddr_q, {UA{1'b0}}};
                        wr_data_d = merged[WIDTH_BYTES-1:0];
                        resid_d   = merged[2*WIDTH_BYTES-1:WIDTH_BYTES];
                        waddr_d   = waddr_inc;
                        cptr_d    = {waddr_inc, {UA{1'b0}}};
                    end else begin
                        resid_d   = merged[WIDTH_BYTES-1:0];
                    end
                end
                if (flush_req) state_d = FLUSH;
            end
            FLUSH: begin
                // waddr/fill stay put so the word is rewritten in full once it completes
                if (fill_q != '0) begin
                    we_d      = 1'b1;
                    wr_addr_d = {waddr_q, {UA{1'b0}}};
                    wr_data_d = resid_q;
                    cptr_d    = {waddr_q, fill_q};
                end
                flush_done_d = 1'b1;
                state_d      = RUN;
            end
            default: state_d = RUN;
        endcase
        in_ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            fill_q       <= '0;
            waddr_q      <= '0;
            resid_q      <= '0;
            in_ready_q   <= 1'b0;
            flush_done_q <= 1'b0;
            we_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cptr_q       <= '0;
        end else begin
            state_q      <= state_d;
            fill_q       <= fill_d;
            waddr_q      <= waddr_d;
            resid_q      <= resid_d;
            in_ready_q   <= in_ready_d;
            flush_done_q <= flush_done_d;
            we_q         <= we_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cptr_q       <= cptr_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign flush_done    = flush_done_q;
    assign write_enable  = we_q;
    assign write_address = wr_addr_q;
    assign write_data    = wr_data_q;
    assign committed_ptr = cptr_q;

endmodule
